// File: rtl/keccak_pkg.sv
// Shared state encoding, widths and byte-lane layout for the keccak message feeder.
package keccak_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  // MSB of each byte lane; lane 0 carries the first byte of a word (big-endian)
  localparam int unsigned LANE0_MSB = 31;
  localparam int unsigned LANE1_MSB = 23;
  localparam int unsigned LANE2_MSB = 15;
  localparam int unsigned LANE3_MSB = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PACK,
    FLUSH,
    WAIT,
    GAP
  } feeder_state_e;

  function automatic logic [WORD_W-1:0] place_byte(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] data
  );
    logic [WORD_W-1:0] r;
    r = word;
    case (lane)
      2'd0: r[LANE0_MSB -: BYTE_W] = data;
      2'd1: r[LANE1_MSB -: BYTE_W] = data;
      2'd2: r[LANE2_MSB -: BYTE_W] = data;
      2'd3: r[LANE3_MSB -: BYTE_W] = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Four-byte big-endian pack register with fill count; clear zeroes the word so
// unused low lanes of a short final word read as 0.
module keccak_byte_packer
  import keccak_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic [2:0]        o_count,
  output logic              o_full
);

  logic [WORD_W-1:0] r_word;
  logic [2:0]        r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_word  <= place_byte(r_word, r_count[1:0], i_byte);
      r_count <= r_count + 3'd1;
    end
  end

  assign o_word  = r_word;
  assign o_count = r_count;
  assign o_full  = (r_count == 3'd4);

endmodule

// File: rtl/keccak_msg_feeder.sv
// Byte-stream to keccak word-interface driver: restart pulse, big-endian packing,
// final-word/flush signalling and digest wait with optional inter-message gap.
module keccak_msg_feeder
  import keccak_pkg::*;
#(
  parameter int unsigned RST_PULSE  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              k_reset,
  output logic [WORD_W-1:0] k_in,
  output logic              k_in_ready,
  output logic              k_is_last,
  output logic [1:0]        k_byte_num,
  input  logic              k_buffer_full,
  input  logic              k_out_ready,
  output logic              busy,
  output logic              msg_done
);

  feeder_state_e r_state;
  feeder_state_e w_state_nxt;

  logic [2:0] r_pulse_cnt;
  logic [7:0] r_gap_cnt;
  logic       r_pending;
  logic       r_is_last;
  logic [1:0] r_byte_num;
  logic       r_flush_pend;
  logic       r_msg_done;

  logic              w_accept;
  logic              w_xfer;
  logic              w_pack_clear;
  logic              w_pulse_done;
  logic              w_gap_done;
  logic [WORD_W-1:0] w_word;
  logic [2:0]        w_count;
  logic [2:0]        w_count_nxt;
  logic              w_full;

  assign s_ready      = (r_state == PACK) && !r_pending;
  assign w_accept     = s_valid && s_ready;
  assign w_xfer       = r_pending && !k_buffer_full;
  assign w_count_nxt  = w_count + 3'd1;
  assign w_pulse_done = (r_pulse_cnt == 3'(RST_PULSE - 1));
  assign w_gap_done   = (r_gap_cnt == 8'(GAP_CYCLES - 1));
  // Clearing on transfer lets the next byte land in lane 0 the following cycle
  assign w_pack_clear = w_xfer || (r_state == IDLE);

  keccak_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (reset),
    .i_clear (w_pack_clear),
    .i_push  (w_accept),
    .i_byte  (s_data),
    .o_word  (w_word),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (s_valid) w_state_nxt = START;
      START:   if (w_pulse_done) w_state_nxt = PACK;
      PACK: begin
        if (w_xfer) begin
          if (r_is_last) begin
            w_state_nxt = WAIT;
          end else if (r_flush_pend) begin
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH:   if (w_xfer) w_state_nxt = WAIT;
      WAIT:    if (k_out_ready) w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (w_gap_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pulse_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_pending    <= 1'b0;
      r_is_last    <= 1'b0;
      r_byte_num   <= '0;
      r_flush_pend <= 1'b0;
      r_msg_done   <= 1'b0;
    end else begin
      r_msg_done  <= (r_state == WAIT) && k_out_ready;
      r_pulse_cnt <= (r_state == START) ? r_pulse_cnt + 3'd1 : '0;
      r_gap_cnt   <= (r_state == GAP) ? r_gap_cnt + 8'd1 : '0;
      if (w_accept) begin
        if (w_count_nxt == 3'd4) begin
          r_pending    <= 1'b1;
          r_is_last    <= 1'b0;
          r_byte_num   <= '0;
          r_flush_pend <= s_last;
        end else if (s_last) begin
          r_pending  <= 1'b1;
          r_is_last  <= 1'b1;
          r_byte_num <= w_count_nxt[1:0];
        end
      end else if (w_xfer) begin
        // A message ending on a word boundary follows its last full word with an empty final word
        if (r_flush_pend) begin
          r_pending    <= 1'b1;
          r_is_last    <= 1'b1;
          r_byte_num   <= '0;
          r_flush_pend <= 1'b0;
        end else begin
          r_pending  <= 1'b0;
          r_is_last  <= 1'b0;
          r_byte_num <= '0;
        end
      end
    end
  end

  assign k_reset    = (r_state == START);
  assign k_in       = w_word;
  assign k_in_ready = r_pending;
  assign k_is_last  = r_is_last;
  assign k_byte_num = r_byte_num;
  assign busy       = (r_state != IDLE);
  assign msg_done   = r_msg_done;

endmodule
